// File: rtl/mempool_tcdm_rob.sv
// mempool_tcdm_rob
//
// Per-core reorder buffer between a core's TCDM master port and the NUMA
// interconnect. Every request that expects a response (reads, and writes when
// WriteRespOn=1) is given an entry index as its tag. Responses may come back
// in any order. They are stored per entry and released to the core strictly
// in issue order.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/addr_i/wen_i/wdata_i/be_i, gnt_o    core request channel
//   rvalid_o/rdata_o, rready_i                in-order response to core
//   req_o/addr_o/wen_o/wdata_o/be_o/tag_o, gnt_i   request to interconnect
//   rvalid_i/rtag_i/rdata_i                   out-of-order responses (always accepted)
//   full_o/empty_o/outstanding_o              occupancy status

module mempool_tcdm_rob #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NumOutstanding = 8,
    parameter bit          WriteRespOn    = 1'b0,
    parameter int unsigned IdWidth        = $clog2(NumOutstanding)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // core side
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   wen_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    input  logic                   rready_i,
    // interconnect side
    output logic                   req_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   wen_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] be_o,
    output logic [IdWidth-1:0]     tag_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic [IdWidth-1:0]     rtag_i,
    input  logic [DataWidth-1:0]   rdata_i,
    // status
    output logic                   full_o,
    output logic                   empty_o,
    output logic [IdWidth:0]       outstanding_o
);

    localparam logic [IdWidth:0] Depth = (IdWidth+1)'(NumOutstanding);

    logic [IdWidth-1:0]        head_q, head_d;
    logic [IdWidth-1:0]        tail_q, tail_d;
    logic [IdWidth:0]          count_q, count_d;
    logic [NumOutstanding-1:0] valid_q, valid_d;
    logic [NumOutstanding-1:0] done_q, done_d;
    logic [DataWidth-1:0]      data_q [NumOutstanding];

    logic alloc;
    logic full;
    logic do_alloc;
    logic do_pop;
    logic rsp_ok;

    // Only requests that will see a response need an entry.
    assign alloc    = ~wen_i | WriteRespOn;
    // Registered count only, so a same-cycle pop never unblocks a request.
    assign full     = (count_q == Depth);

    assign req_o    = req_i & (~alloc | ~full);
    assign gnt_o    = req_o & gnt_i;
    assign do_alloc = req_o & gnt_i & alloc;

    assign addr_o   = addr_i;
    assign wen_o    = wen_i;
    assign wdata_o  = wdata_i;
    assign be_o     = be_i;
    assign tag_o    = tail_q;

    // Responses to free or already completed entries are dropped.
    assign rsp_ok   = rvalid_i & valid_q[rtag_i] & ~done_q[rtag_i];

    assign rvalid_o = valid_q[head_q] & done_q[head_q];
    assign rdata_o  = data_q[head_q];
    assign do_pop   = rvalid_o & rready_i;

    assign full_o        = full;
    assign empty_o       = (count_q == '0);
    assign outstanding_o = count_q;

    // Alloc targets a free entry, pop a done one and a response an allocated,
    // not-done one, so the three updates below never touch the same entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (do_alloc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + 1'b1;
        end
        if (rsp_ok) begin
            done_d[rtag_i] = 1'b1;
        end
        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
        end

        unique case ({do_alloc, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Response storage is not reset; an entry is only read once marked done.
    always_ff @(posedge clk_i) begin
        if (rsp_ok) begin
            data_q[rtag_i] <= rdata_i;
        end
    end

`ifndef SYNTHESIS
    rsp_tag_check: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_i |-> (valid_q[rtag_i] && !done_q[rtag_i]))
        else $warning("rob: dropped response for tag %0d (entry not outstanding or already done)", rtag_i);
`endif

endmodule

// File: tb/tb_mempool_tcdm_rob.sv
module tb_mempool_tcdm_rob;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // shared core / interconnect stimulus
    logic        c_req, c_wen, c_rready;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        i_gnt, i_rvalid;
    logic [2:0]  i_rtag;
    logic [31:0] i_rdata;

    // instance with WriteRespOn=0
    logic        o_gnt, o_rvalid, o_req, o_wen, o_full, o_empty;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;
    logic [2:0]  o_tag;
    logic [3:0]  o_out;

    // instance with WriteRespOn=1
    logic        c_req1, i_rvalid1;
    logic        p_gnt, p_rvalid, p_req, p_wen, p_full, p_empty;
    logic [31:0] p_rdata, p_addr, p_wdata;
    logic [3:0]  p_be;
    logic [2:0]  p_tag;
    logic [3:0]  p_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [2:0]  exp_tail;
    logic [31:0] tag_data [8];
    bit          pend [8];

    always #5 clk = ~clk;

    mempool_tcdm_rob #(.NumOutstanding(8), .WriteRespOn(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(c_req), .addr_i(c_addr), .wen_i(c_wen), .wdata_i(c_wdata), .be_i(c_be),
        .gnt_o(o_gnt), .rvalid_o(o_rvalid), .rdata_o(o_rdata), .rready_i(c_rready),
        .req_o(o_req), .addr_o(o_addr), .wen_o(o_wen), .wdata_o(o_wdata), .be_o(o_be),
        .tag_o(o_tag), .gnt_i(i_gnt), .rvalid_i(i_rvalid), .rtag_i(i_rtag), .rdata_i(i_rdata),
        .full_o(o_full), .empty_o(o_empty), .outstanding_o(o_out)
    );

    mempool_tcdm_rob #(.NumOutstanding(8), .WriteRespOn(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(c_req1), .addr_i(c_addr), .wen_i(c_wen), .wdata_i(c_wdata), .be_i(c_be),
        .gnt_o(p_gnt), .rvalid_o(p_rvalid), .rdata_o(p_rdata), .rready_i(c_rready),
        .req_o(p_req), .addr_o(p_addr), .wen_o(p_wen), .wdata_o(p_wdata), .be_o(p_be),
        .tag_o(p_tag), .gnt_i(i_gnt), .rvalid_i(i_rvalid1), .rtag_i(i_rtag), .rdata_i(i_rdata),
        .full_o(p_full), .empty_o(p_empty), .outstanding_o(p_out)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // in-order delivery scoreboard for the WriteRespOn=0 instance
    always @(negedge clk) begin
        if (rst_n && o_rvalid && c_rready) begin
            if (exp_q.size() == 0) check_val("rsp_extra", 64'(exp_q.size()), 64'd1);
            else                   check_val("rsp_data", o_rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d);
        c_req = 1'b1; c_wen = 1'b0; c_addr = a; i_gnt = 1'b1;
        settle();
        check_val("rd_gnt", o_gnt, 1);
        check_val("rd_tag", o_tag, exp_tail);
        check_val("rd_addr", o_addr, a);
        tag_data[exp_tail] = d;
        pend[exp_tail] = 1'b1;
        exp_q.push_back(d);
        exp_tail = exp_tail + 3'd1;
        tick();
        c_req = 1'b0; i_gnt = 1'b0;
    endtask

    task automatic resp(input logic [2:0] t, input logic [31:0] d);
        i_rvalid = 1'b1; i_rtag = t; i_rdata = d;
        pend[t] = 1'b0;
        tick();
        i_rvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        c_rready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) resp(3'(i), tag_data[i]);
        end
        for (int k = 0; k < 40 && !(o_empty && exp_q.size() == 0); k++) tick();
        check_val({tag, "_empty"}, o_empty, 1);
        check_val({tag, "_sb"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] h;
        c_req = 1'b1; c_wen = 1'b0; c_rready = 1'b1; c_addr = '0; c_wdata = '0; c_be = 4'hF;
        i_gnt = 1'b1; i_rvalid = 1'b0; i_rtag = '0; i_rdata = '0;
        c_req1 = 1'b0; i_rvalid1 = 1'b0;
        exp_tail = '0;
        for (int i = 0; i < 8; i++) begin pend[i] = 1'b0; tag_data[i] = '0; end

        // values while in reset
        settle();
        check_val("rst_req_o", o_req, 1);
        check_val("rst_gnt_o", o_gnt, 1);
        check_val("rst_rvalid", o_rvalid, 0);
        check_val("rst_full", o_full, 0);
        check_val("rst_empty", o_empty, 1);
        check_val("rst_out", o_out, 0);
        check_val("rst_tag", o_tag, 0);
        check_val("rst_out1", p_out, 0);
        c_req = 1'b0; i_gnt = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // single read with a response two cycles later
        rd(32'h100, 32'hDEADBEEF);
        tick();
        i_rvalid = 1'b1; i_rtag = 3'd0; i_rdata = 32'hDEADBEEF; pend[0] = 1'b0;
        settle();
        check_val("single_no_bypass", o_rvalid, 0);
        tick();
        i_rvalid = 1'b0;
        settle();
        check_val("single_rvalid", o_rvalid, 1);
        tick();
        check_val("single_empty", o_empty, 1);

        // out-of-order responses, in-order delivery
        h = exp_tail;
        rd(32'h200, 32'hA);
        rd(32'h204, 32'hB);
        rd(32'h208, 32'hC);
        resp(h + 3'd2, 32'hC);
        check_val("ooo_hold", o_rvalid, 0);
        resp(h, 32'hA);
        resp(h + 3'd1, 32'hB);
        drain("ooo");

        // fill to full, blocked 9th read, unblock one cycle after pop
        h = exp_tail;
        for (int k = 0; k < 8; k++) rd(32'h1000 + 32'(4 * k), 32'h1000 + 32'(k));
        check_val("full_flag", o_full, 1);
        check_val("full_out", o_out, 8);
        c_req = 1'b1; c_wen = 1'b0; i_gnt = 1'b1;
        settle();
        check_val("full_req_o", o_req, 0);
        check_val("full_gnt_o", o_gnt, 0);
        tick();
        c_req = 1'b0;
        resp(h + 3'd3, tag_data[h + 3'd3]);
        check_val("full_still", o_full, 1);
        resp(h, tag_data[h]);
        c_req = 1'b1;
        settle();
        check_val("full_pop_rvalid", o_rvalid, 1);
        check_val("full_pop_req_o", o_req, 0);
        tick();
        check_val("full_clear", o_full, 0);
        rd(32'h2000, 32'h2000);
        drain("full");

        // backpressure: response held stable while rready is low
        c_rready = 1'b0;
        h = exp_tail;
        rd(32'h300, 32'hCAFE0001);
        resp(h, 32'hCAFE0001);
        for (int k = 0; k < 5; k++) begin
            settle();
            check_val("bp_rvalid", o_rvalid, 1);
            check_val("bp_rdata", o_rdata, 32'hCAFE0001);
            check_val("bp_out", o_out, 1);
            tick();
        end
        c_rready = 1'b1;
        settle();
        tick();
        check_val("bp_popped", o_out, 0);

        // fire-and-forget write while full
        for (int k = 0; k < 8; k++) rd(32'h400 + 32'(4 * k), 32'h4000 + 32'(k));
        check_val("wr_full", o_full, 1);
        h = o_tag;
        c_req = 1'b1; c_wen = 1'b1; c_wdata = 32'h77; c_be = 4'h3; i_gnt = 1'b1;
        settle();
        check_val("wr_req_o", o_req, 1);
        check_val("wr_gnt_o", o_gnt, 1);
        check_val("wr_wen_o", o_wen, 1);
        check_val("wr_wdata_o", o_wdata, 32'h77);
        check_val("wr_be_o", o_be, 4'h3);
        tick();
        c_req = 1'b0; c_wen = 1'b0; i_gnt = 1'b0;
        check_val("wr_out", o_out, 8);
        check_val("wr_tag", o_tag, h);
        drain("wr");

        // write with response on the WriteRespOn=1 instance
        c_req1 = 1'b1; c_wen = 1'b1; c_wdata = 32'h55; i_gnt = 1'b1;
        settle();
        check_val("wr1_gnt", p_gnt, 1);
        check_val("wr1_tag", p_tag, 0);
        tick();
        c_req1 = 1'b0; c_wen = 1'b0; i_gnt = 1'b0;
        check_val("wr1_out", p_out, 1);
        check_val("wr1_no_rsp", p_rvalid, 0);
        i_rvalid1 = 1'b1; i_rtag = 3'd0; i_rdata = 32'h5A5A5A5A;
        tick();
        i_rvalid1 = 1'b0;
        settle();
        check_val("wr1_rvalid", p_rvalid, 1);
        check_val("wr1_rdata", p_rdata, 32'h5A5A5A5A);
        tick();
        check_val("wr1_pulse_end", p_rvalid, 0);
        check_val("wr1_out_end", p_out, 0);

        // reset in the middle of traffic
        c_rready = 1'b0;
        h = exp_tail;
        for (int k = 0; k < 4; k++) rd(32'h500 + 32'(4 * k), 32'h5000 + 32'(k));
        resp(h, tag_data[h]);
        settle();
        check_val("mid_rvalid", o_rvalid, 1);
        check_val("mid_out", o_out, 4);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out", o_out, 0);
        check_val("mid_rst_rvalid", o_rvalid, 0);
        check_val("mid_rst_tag", o_tag, 0);
        exp_q.delete();
        exp_tail = '0;
        for (int i = 0; i < 8; i++) pend[i] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        c_rready = 1'b1;
        resp(3'd2, 32'hBAD0BAD0);
        settle();
        check_val("stray_rvalid", o_rvalid, 0);
        check_val("stray_out", o_out, 0);
        tick();
        rd(32'h600, 32'h600D600D);
        resp(3'd0, 32'h600D600D);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
